// File: rtl/multiplier_controller.sv
// ---------------------------------------------------------------------------
// multiplier_controller
//
// Sequencer for an N-bit shift/add multiplier datapath. One accepted start
// produces one INIT cycle (operand load), N SHIFT cycles (one add/shift step
// each) and a single DONE cycle during which the datapath product is valid.
// All outputs are Moore outputs decoded from the state register.
//
// Parameters
//   N         datapath width in bits and number of shift steps (N >= 1)
//
// Ports
//   clock     in   system clock, rising-edge active
//   n_reset   in   asynchronous active-low reset
//   start     in   begin one multiplication (honoured only when idle)
//   abort     in   (only with MULTIPLIER_CONTROLLER_ABORT_EN) cancel an
//                  operation in INIT or SHIFT, returning to IDLE, no done
//   ready     out  idle and able to accept start
//   busy      out  operation in progress (INIT or SHIFT)
//   do_init   out  datapath operand load strobe
//   do_shift  out  datapath add/shift strobe
//   done      out  one-cycle pulse, product valid
//
// Optional feature macro: MULTIPLIER_CONTROLLER_ABORT_EN
// ---------------------------------------------------------------------------
module multiplier_controller #(
  parameter int N = 4
) (
  input  logic clock,
  input  logic n_reset,
  input  logic start,
`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
  input  logic abort,
`endif
  output logic ready,
  output logic busy,
  output logic do_init,
  output logic do_shift,
  output logic done
);

  // One extra count value of headroom keeps the width legal for N = 1.
  localparam int             CW   = $clog2(N + 1);
  localparam logic [CW-1:0]  LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            abort_w;

`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = INIT;
      end
      INIT: begin
        cnt_d = '0;
        // Abort outranks the unconditional advance.
        state_d = abort_w ? IDLE : SHIFT;
      end
      SHIFT: begin
        cnt_d = cnt_q + CW'(1);
        if (abort_w)            state_d = IDLE;
        else if (cnt_q == LAST) state_d = DONE;
      end
      DONE: begin
        // Abort is deliberately ignored here: the result is already valid.
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ready    = 1'b0;
    busy     = 1'b0;
    do_init  = 1'b0;
    do_shift = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      IDLE:  ready = 1'b1;
      INIT:  begin do_init  = 1'b1; busy = 1'b1; end
      SHIFT: begin do_shift = 1'b1; busy = 1'b1; end
      DONE:  done = 1'b1;
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_multiplier_controller.sv
module tb_multiplier_controller;

  localparam int N = 4;
`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  localparam logic [4:0] E_IDLE  = 5'b10000;
  localparam logic [4:0] E_INIT  = 5'b01100;
  localparam logic [4:0] E_SHIFT = 5'b01010;
  localparam logic [4:0] E_DONE  = 5'b00001;

  logic clock = 1'b0;
  logic n_reset;
  logic start;
  logic abort_r;
  logic ready, busy, do_init, do_shift, done;

  logic start1;
  logic ready1, busy1, do_init1, do_shift1, done1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multiplier_controller #(.N(N)) u_dut (
    .clock    (clock),
    .n_reset  (n_reset),
    .start    (start),
`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
    .abort    (abort_r),
`endif
    .ready    (ready),
    .busy     (busy),
    .do_init  (do_init),
    .do_shift (do_shift),
    .done     (done)
  );

  multiplier_controller #(.N(1)) u_dut1 (
    .clock    (clock),
    .n_reset  (n_reset),
    .start    (start1),
`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
    .abort    (1'b0),
`endif
    .ready    (ready1),
    .busy     (busy1),
    .do_init  (do_init1),
    .do_shift (do_shift1),
    .done     (done1)
  );

  // Behavioural shift/add datapath driven by the controller strobes.
  int op_a, op_b;
  int acc, mc, mp, sh;
  always_ff @(posedge clock) begin
    if (do_init) begin
      acc <= 0; mc <= op_a; mp <= op_b; sh <= 0;
    end else if (do_shift) begin
      if (mp[0]) acc <= acc + (mc << sh);
      mp <= mp >> 1;
      sh <= sh + 1;
    end
  end

  // Reference model: an operation is remembered only by the edge index at
  // which its start was accepted; the expected outputs follow from the
  // distance to that edge (0 = INIT, 1..N = SHIFT, N+1 = DONE).
  int edge_n = 0;
  int op_k   = -1;

  task automatic model_update(input logic s, input logic a);
    int d;
    if (!n_reset) begin
      op_k = -1;
    end else if (op_k < 0) begin
      if (s) op_k = edge_n;
    end else begin
      d = edge_n - 1 - op_k;
      if (ABORT_EN && a && d <= N) op_k = -1;
      else if (d >= N + 1)         op_k = -1;
    end
  endtask

  function automatic logic [4:0] model_exp();
    int d;
    if (op_k < 0) return E_IDLE;
    d = edge_n - op_k;
    if (d == 0) return E_INIT;
    if (d <= N) return E_SHIFT;
    return E_DONE;
  endfunction

  task automatic check(input string nm, input logic [4:0] exp);
    logic [4:0] got;
    got = {ready, busy, do_init, do_shift, done};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {rdy,bsy,ini,shf,dn}=%b expected=%b (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic check_prod(input string nm);
    total++;
    if (acc !== 66) begin
      bad++;
      $display("FAIL %s: product=%0d expected=66", nm, acc);
    end
  endtask

  // Drive inputs, advance one clock, update the model, check at the negedge.
  task automatic cycle(input logic s, input logic a, input string nm);
    start   = s;
    abort_r = a;
    @(posedge clock);
    edge_n++;
    model_update(s, a);
    @(negedge clock);
    check(nm, model_exp());
  endtask

  typedef struct {
    logic       st;
    logic [4:0] exp;
    logic       chk_p;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int n_init, n_done, n_shift1, n_done1, done_at;

    tbl[0] = '{1'b1, E_INIT,  1'b0};
    tbl[1] = '{1'b0, E_SHIFT, 1'b0};
    tbl[2] = '{1'b0, E_SHIFT, 1'b0};
    tbl[3] = '{1'b0, E_SHIFT, 1'b0};
    tbl[4] = '{1'b0, E_SHIFT, 1'b0};
    tbl[5] = '{1'b0, E_DONE,  1'b1};
    tbl[6] = '{1'b0, E_IDLE,  1'b1};
    tbl[7] = '{1'b0, E_IDLE,  1'b1};

    n_reset = 1'b0;
    start   = 1'b1;
    start1  = 1'b0;
    abort_r = 1'b0;
    op_a    = 11;
    op_b    = 6;
    #1;
    check("reset_async", E_IDLE);

    // Reset held with start high: must stay idle.
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, "reset_hold");
    n_reset = 1'b1;
    cycle(1'b0, 1'b0, "post_reset_idle");

    // 11 x 6 operation, table driven.
    for (int i = 0; i < 8; i++) begin
      cycle(tbl[i].st, 1'b0, "tbl_model");
      check($sformatf("tbl_row%0d", i), tbl[i].exp);
      if (tbl[i].chk_p) check_prod($sformatf("tbl_prod%0d", i));
    end

    // start held high for 20 cycles: 7-cycle repeating pattern.
    n_init = 0;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, "start_held");
      if (do_init) n_init++;
      if (done)    n_done++;
    end
    total++;
    if (n_init != 3 || n_done != 3) begin
      bad++;
      $display("FAIL start_held_count: inits=%0d dones=%0d expected 3/3", n_init, n_done);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "drain");

    // start pulses while busy must not queue.
    cycle(1'b1, 1'b0, "busy_pulse");
    for (int i = 0; i < 8; i++) cycle(i[0], 1'b0, "busy_pulse");

    // Reset during the 2nd shift cycle.
    cycle(1'b1, 1'b0, "rst_mid");
    cycle(1'b0, 1'b0, "rst_mid");
    cycle(1'b0, 1'b0, "rst_mid");
    n_reset = 1'b0;
    #1;
    op_k = -1;
    check("rst_mid_async", E_IDLE);
    #1;
    n_reset = 1'b1;
    cycle(1'b0, 1'b0, "rst_mid_after");
    done_at = -1;
    cycle(1'b1, 1'b0, "rst_restart");
    for (int i = 2; i <= N + 4; i++) begin
      cycle(1'b0, 1'b0, "rst_restart");
      if (done && done_at < 0) done_at = i;
    end
    total++;
    if (done_at != N + 2) begin
      bad++;
      $display("FAIL rst_restart_latency: done in cycle %0d expected %0d", done_at, N + 2);
    end

`ifdef MULTIPLIER_CONTROLLER_ABORT_EN
    // Abort in the 3rd shift cycle.
    cycle(1'b1, 1'b0, "abort_shift");
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, "abort_shift");
    cycle(1'b0, 1'b1, "abort_shift");
    check("abort_shift_idle", E_IDLE);
    cycle(1'b0, 1'b0, "abort_shift_after");
    // Abort during DONE is ignored: the done pulse stays one cycle.
    cycle(1'b1, 1'b0, "abort_done");
    for (int i = 0; i < N; i++) cycle(1'b0, 1'b0, "abort_done");
    cycle(1'b0, 1'b0, "abort_done");
    check("abort_done_pulse", E_DONE);
    cycle(1'b0, 1'b1, "abort_done");
    check("abort_done_idle", E_IDLE);
    // Abort in INIT.
    cycle(1'b1, 1'b0, "abort_init");
    cycle(1'b0, 1'b1, "abort_init");
    check("abort_init_idle", E_IDLE);
`endif

    // N = 1 instance: exactly one shift cycle and one done pulse.
    n_shift1 = 0;
    n_done1  = 0;
    start1   = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      if (do_shift1) n_shift1++;
      if (done1)     n_done1++;
    end
    total++;
    if (n_shift1 != 1 || n_done1 != 1) begin
      bad++;
      $display("FAIL n1_build: shifts=%0d dones=%0d expected 1/1", n_shift1, n_done1);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0), "random");
      total++;
      if ((do_init && do_shift) || ((32'(ready) + 32'(busy) + 32'(done)) != 1)) begin
        bad++;
        $display("FAIL random_exclusive: rdy=%b bsy=%b dn=%b ini=%b shf=%b",
                 ready, busy, done, do_init, do_shift);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
